// File: rtl/opsel_wb_pipe.sv
// opsel_wb_pipe
// Operand-2 select and writeback-source select stage. It sits behind a
// two-entry skid FIFO. Every accepted entry is decoded on the way in:
//   - the operand-2 mux (rs2 / immediate / pc / zero) is resolved,
//   - the immediate is decoded,
//   - the writeback source is picked,
// and the results are stored. The head entry drives the outputs, so an
// entry pushed in one cycle appears at the outputs in the next cycle.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   in_valid / in_ready     upstream handshake (in_ready = room available)
//   wb_sel, wb_src          writeback source index and flattened sources
//   op2_sel, imm_mode       operand-2 mux select and immediate format
//   inst_hi                 instruction bits [31:7] (inst_hi[i] = instr[i+7])
//   pc, rs2, rs2_addr       operand candidates
//   rd_addr, rd_we          destination register and write enable
//   flush                   synchronous discard of all held entries
//   out_valid / out_ready   downstream handshake
//   op2_out, wb_out,
//   wb_rd_addr, wb_we       head entry, forced to zero while empty
//
// Build option: define OPSEL_FWD_EN to add a forwarding register. This
// register captures each popped writeback and bypasses it into rs2 for
// later pushes. The port list and timing are the same with or without it.
module opsel_wb_pipe #(
    parameter int XLEN = 32,
    parameter int NSRC = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [$clog2(NSRC)-1:0]   wb_sel,
    input  logic [NSRC*XLEN-1:0]      wb_src,
    input  logic [1:0]                op2_sel,
    input  logic [1:0]                imm_mode,
    input  logic [24:0]               inst_hi,
    input  logic [XLEN-1:0]           pc,
    input  logic [XLEN-1:0]           rs2,
    input  logic [4:0]                rs2_addr,
    input  logic [4:0]                rd_addr,
    input  logic                      rd_we,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           op2_out,
    output logic [XLEN-1:0]           wb_out,
    output logic [4:0]                wb_rd_addr,
    output logic                      wb_we
);

    localparam int SELW = $clog2(NSRC);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    typedef struct packed {
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] wb;
        logic [4:0]      rd;
        logic            we;
    } entry_t;

    occ_t            occ_q;
    entry_t          head_q;
    entry_t          tail_q;
    entry_t          new_ent;
    logic            push;
    logic            pop;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] wb_pick;
    logic [XLEN-1:0] rs2_eff;

    // Handshake status depends only on the occupancy state.
    assign in_ready  = (occ_q != OCC_FULL);
    assign out_valid = (occ_q != OCC_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Immediate decode. inst_hi is offset by 7 from the instruction bit
    // numbering, so instr[k] appears as inst_hi[k-7] in the slices below.
    always_comb begin
        imm32 = '0;
        case (imm_mode)
            2'b00:   imm32 = {{20{inst_hi[24]}}, inst_hi[24:13]};
            2'b01:   imm32 = {{20{inst_hi[24]}}, inst_hi[24:18], inst_hi[4:0]};
            2'b10:   imm32 = {inst_hi[24:5], 12'b0};
            default: imm32 = {{11{inst_hi[24]}}, inst_hi[24], inst_hi[12:5],
                              inst_hi[13], inst_hi[23:14], 1'b0};
        endcase
        imm_ext = XLEN'($signed(imm32));
    end

    // Writeback source mux. An index beyond the last source matches
    // nothing and leaves the result at zero.
    always_comb begin
        wb_pick = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (wb_sel == SELW'(k)) begin
                wb_pick = wb_src[k*XLEN +: XLEN];
            end
        end
    end

`ifdef OPSEL_FWD_EN
    logic            fwd_valid_q;
    logic [4:0]      fwd_addr_q;
    logic [XLEN-1:0] fwd_value_q;
    logic            fwd_v;
    logic [4:0]      fwd_a;
    logic [XLEN-1:0] fwd_d;

    // Forwarding source for this cycle. When the head is popping in the
    // same cycle, that entry is what the register is about to hold, so it
    // is compared directly instead of the stale register contents.
    always_comb begin
        fwd_v = fwd_valid_q;
        fwd_a = fwd_addr_q;
        fwd_d = fwd_value_q;
        if (pop) begin
            fwd_v = head_q.we;
            fwd_a = head_q.rd;
            fwd_d = head_q.wb;
        end
        rs2_eff = rs2;
        if (fwd_v && (fwd_a == rs2_addr) && (rs2_addr != 5'd0)) begin
            rs2_eff = fwd_d;
        end
    end

    // The forwarding register captures every popped entry. A flush leaves
    // it alone because nothing actually leaves the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_value_q <= '0;
        end else if (!flush && pop) begin
            fwd_valid_q <= head_q.we;
            fwd_addr_q  <= head_q.rd;
            fwd_value_q <= head_q.wb;
        end
    end
`else
    logic unused_rs2_addr;

    assign unused_rs2_addr = ^rs2_addr;
    assign rs2_eff         = rs2;
`endif

    // Assemble the entry that would be stored if a push happens now.
    always_comb begin
        new_ent    = '0;
        new_ent.wb = wb_pick;
        new_ent.rd = rd_addr;
        new_ent.we = rd_we && (rd_addr != 5'd0);
        case (op2_sel)
            2'b00:   new_ent.op2 = rs2_eff;
            2'b01:   new_ent.op2 = imm_ext;
            2'b10:   new_ent.op2 = pc;
            default: new_ent.op2 = '0;
        endcase
    end

    // Two-slot FIFO. The head slot always drives the outputs.
    //   - With one entry, a simultaneous push and pop replaces the head.
    //   - With two entries, a pop promotes the tail.
    //   - A flush overrides any push or pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else if (flush) begin
            occ_q <= OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (push) begin
                        head_q <= new_ent;
                        occ_q  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head_q <= new_ent;
                    end else if (push) begin
                        tail_q <= new_ent;
                        occ_q  <= OCC_FULL;
                    end else if (pop) begin
                        occ_q <= OCC_EMPTY;
                    end
                end
                default: begin
                    if (pop) begin
                        head_q <= tail_q;
                        occ_q  <= OCC_ONE;
                    end
                end
            endcase
        end
    end

    // Data outputs read as zero whenever nothing is held. This covers the
    // asynchronous reset case too, because reset clears the occupancy at once.
    assign op2_out    = out_valid ? head_q.op2 : '0;
    assign wb_out     = out_valid ? head_q.wb  : '0;
    assign wb_rd_addr = out_valid ? head_q.rd  : '0;
    assign wb_we      = out_valid ? head_q.we  : 1'b0;

endmodule

// File: tb/tb_opsel_wb_pipe.sv
// tb_opsel_wb_pipe
// Self-checking bench for opsel_wb_pipe.
//   - The main instance uses the defaults (XLEN=32, NSRC=4).
//   - A second instance uses NSRC=3 and covers the out-of-range writeback
//     select.
// Every accepted push enqueues the entry the bench expects. The head of
// that queue is compared against the DUT outputs on each falling edge.
// Define OPSEL_FWD_EN to check the forwarding build.
`timescale 1ns/1ps
module tb_opsel_wb_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  wb_sel;
    logic [127:0] wb_src;
    logic [1:0]  op2_sel;
    logic [1:0]  imm_mode;
    logic [24:0] inst_hi;
    logic [31:0] pc;
    logic [31:0] rs2;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op2_out;
    logic [31:0] wb_out;
    logic [4:0]  wb_rd_addr;
    logic        wb_we;

    logic [1:0]  wb_sel3;
    logic [95:0] wb_src3;
    logic        d3_in_ready;
    logic        d3_out_valid;
    logic [31:0] d3_op2_out;
    logic [31:0] d3_wb_out;
    logic [4:0]  d3_wb_rd_addr;
    logic        d3_wb_we;

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        logic [31:0] op2;
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t sb[$];

`ifdef OPSEL_FWD_EN
    logic        fwd_v = 1'b0;
    logic [4:0]  fwd_a = '0;
    logic [31:0] fwd_d = '0;
`endif

    assign wb_src3 = wb_src[95:0];

    always #5 clk = ~clk;

    opsel_wb_pipe #(.XLEN(32), .NSRC(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .wb_sel(wb_sel), .wb_src(wb_src), .op2_sel(op2_sel), .imm_mode(imm_mode),
        .inst_hi(inst_hi), .pc(pc), .rs2(rs2), .rs2_addr(rs2_addr),
        .rd_addr(rd_addr), .rd_we(rd_we), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .op2_out(op2_out), .wb_out(wb_out),
        .wb_rd_addr(wb_rd_addr), .wb_we(wb_we)
    );

    opsel_wb_pipe #(.XLEN(32), .NSRC(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d3_in_ready),
        .wb_sel(wb_sel3), .wb_src(wb_src3), .op2_sel(op2_sel), .imm_mode(imm_mode),
        .inst_hi(inst_hi), .pc(pc), .rs2(rs2), .rs2_addr(rs2_addr),
        .rd_addr(rd_addr), .rd_we(rd_we), .flush(flush), .out_valid(d3_out_valid),
        .out_ready(out_ready), .op2_out(d3_op2_out), .wb_out(d3_wb_out),
        .wb_rd_addr(d3_wb_rd_addr), .wb_we(d3_wb_we)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h",
                     tag, observed, expected);
        end
    endtask

    // Reference immediate decode, built from the full 32-bit instruction.
    function automatic logic [31:0] immModel(input logic [1:0] m, input logic [24:0] h);
        logic [31:0] ins;
        ins = {h, 7'b0};
        case (m)
            2'b00:   return {{20{ins[31]}}, ins[31:20]};
            2'b01:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            2'b10:   return {ins[31:12], 12'b0};
            default: return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        endcase
    endfunction

    // Expected stored entry for a push with the given inputs.
    function automatic exp_t buildExp(input logic [1:0] o2s, input logic [1:0] im,
                                      input logic [24:0] ihi, input logic [31:0] pcv,
                                      input logic [31:0] rs2v, input logic [4:0] rs2a,
                                      input logic [4:0] rda, input logic rdwe,
                                      input logic [31:0] selval);
        exp_t e;
        logic [31:0] src2;
        src2 = rs2v;
`ifdef OPSEL_FWD_EN
        if (fwd_v && (fwd_a == rs2a) && (rs2a != 5'd0)) src2 = fwd_d;
`endif
        case (o2s)
            2'b00:   e.op2 = src2;
            2'b01:   e.op2 = immModel(im, ihi);
            2'b10:   e.op2 = pcv;
            default: e.op2 = 32'd0;
        endcase
        e.wb = selval;
        e.rd = rda;
        e.we = rdwe && (rda != 5'd0);
        return e;
    endfunction

    // Compare the DUT head and handshake status against the scoreboard.
    task automatic checkHead();
        checkOutput("in_ready", 32'(in_ready), (sb.size() < 2) ? 32'd1 : 32'd0);
        if (sb.size() > 0) begin
            checkOutput("out_valid", 32'(out_valid), 32'd1);
            checkOutput("op2_out", op2_out, sb[0].op2);
            checkOutput("wb_out", wb_out, sb[0].wb);
            checkOutput("wb_rd_addr", 32'(wb_rd_addr), 32'(sb[0].rd));
            checkOutput("wb_we", 32'(wb_we), 32'(sb[0].we));
        end else begin
            checkOutput("out_valid_empty", 32'(out_valid), 32'd0);
            checkOutput("op2_out_empty", op2_out, 32'd0);
            checkOutput("wb_out_empty", wb_out, 32'd0);
            checkOutput("wb_rd_empty", 32'(wb_rd_addr), 32'd0);
            checkOutput("wb_we_empty", 32'(wb_we), 32'd0);
        end
    endtask

    // Drive one cycle, check the current head, then advance the model.
    task automatic applyStimulus(input logic iv, input logic ordy, input logic fl,
                                 input logic [1:0] o2s, input logic [1:0] im,
                                 input logic [24:0] ihi, input logic [31:0] rs2v,
                                 input logic [4:0] rs2a, input logic [4:0] rda,
                                 input logic rdwe, input logic [1:0] sel,
                                 input logic [31:0] selval);
        logic do_push;
        logic do_pop;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        op2_sel   = o2s;
        imm_mode  = im;
        inst_hi   = ihi;
        rs2       = rs2v;
        rs2_addr  = rs2a;
        rd_addr   = rda;
        rd_we     = rdwe;
        wb_sel    = sel;
        pc        = $urandom;
        for (int k = 0; k < 4; k++) begin
            wb_src[k*32 +: 32] = (k == int'(sel)) ? selval : $urandom;
        end
        @(negedge clk);
        checkHead();
        do_push = iv && (sb.size() < 2);
        do_pop  = ordy && (sb.size() > 0);
        if (fl) begin
            sb.delete();
        end else begin
            if (do_pop) begin
`ifdef OPSEL_FWD_EN
                fwd_v = sb[0].we;
                fwd_a = sb[0].rd;
                fwd_d = sb[0].wb;
`endif
                sb.delete(0);
            end
            if (do_push) begin
                sb.push_back(buildExp(o2s, im, ihi, pc, rs2v, rs2a, rda, rdwe, selval));
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] pickAddr();
        case ($urandom_range(0, 2))
            0:       return 5'd0;
            1:       return 5'd5;
            default: return 5'd6;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        wb_sel = '0; wb_src = '0; op2_sel = '0; imm_mode = '0; inst_hi = '0;
        pc = '0; rs2 = '0; rs2_addr = '0; rd_addr = '0; rd_we = 1'b0;
        wb_sel3 = '0;

        // Reset state
        #2;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_op2_out", op2_out, 32'd0);
        checkOutput("rst_wb_out", wb_out, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // I-type immediate of all ones is visible one cycle after the push
        applyStimulus(1, 0, 0, 2'b01, 2'b00, 25'h1FFE000, 0, 0, 5'd3, 1, 2'd0, 32'h11);
        checkOutput("imm_i_ones_valid", 32'(out_valid), 32'd1);
        checkOutput("imm_i_ones", op2_out, 32'hFFFF_FFFF);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Writeback source select, including out-of-range on NSRC=3
        wb_sel3 = 2'd2;
        applyStimulus(1, 0, 0, 2'b10, 0, 0, 0, 0, 5'd4, 1, 2'd2, 32'h0000_1004);
        checkOutput("wb_sel2", wb_out, 32'h0000_1004);
        checkOutput("nsrc3_sel2", d3_wb_out, 32'h0000_1004);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb_sel3 = 2'd3;
        applyStimulus(1, 0, 0, 2'b11, 0, 0, 0, 0, 5'd4, 1, 2'd1, 32'hCAFE_0001);
        checkOutput("nsrc3_sel3_valid", 32'(d3_out_valid), 32'd1);
        checkOutput("nsrc3_sel3_zero", d3_wb_out, 32'd0);
        wb_sel3 = 2'd0;
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // U-type and S-type decode, then fill to two with stall; third push ignored
        applyStimulus(1, 0, 0, 2'b01, 2'b10, 25'h0246_8AB, 0, 0, 5'd7, 1, 2'd3, 32'hA1);
        checkOutput("imm_u", op2_out, immModel(2'b10, 25'h0246_8AB));
        applyStimulus(1, 0, 0, 2'b01, 2'b01, 25'h1F0_0015, 0, 0, 5'd8, 1, 2'd0, 32'hA2);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1, 0, 0, 2'b10, 2'b00, 0, 0, 0, 5'd9, 1, 2'd1, 32'hA3);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Push and pop together at one entry, then flush while full
        applyStimulus(1, 0, 0, 2'b01, 2'b11, 25'h1ABCDEF, 0, 0, 5'd10, 1, 2'd2, 32'hB1);
        applyStimulus(1, 1, 0, 2'b01, 2'b11, 25'h0123456, 0, 0, 5'd11, 1, 2'd3, 32'hB2);
        applyStimulus(1, 0, 0, 2'b00, 0, 0, 32'h55, 5'd1, 5'd12, 1, 2'd0, 32'hB3);
        applyStimulus(1, 1, 1, 2'b00, 0, 0, 32'h66, 5'd1, 5'd13, 1, 2'd1, 32'hB4);
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Forwarding from a popping entry, then from an rd=0 entry
        applyStimulus(1, 0, 0, 2'b11, 0, 0, 0, 0, 5'd5, 1, 2'd1, 32'hDEAD_BEEF);
        applyStimulus(1, 1, 0, 2'b00, 0, 0, 32'd0, 5'd5, 5'd0, 1, 2'd0, 32'h0000_0042);
`ifdef OPSEL_FWD_EN
        checkOutput("fwd_hit", op2_out, 32'hDEAD_BEEF);
`else
        checkOutput("fwd_hit", op2_out, 32'd0);
`endif
        applyStimulus(1, 1, 0, 2'b00, 0, 0, 32'd0, 5'd5, 5'd6, 1, 2'd2, 32'h0000_0077);
        checkOutput("fwd_rd0", op2_out, 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset with one entry held and the output stalled
        applyStimulus(1, 0, 0, 2'b01, 2'b11, 25'h1FFFFFF, 0, 0, 5'd7, 1, 2'd3, 32'h1357_9BDF);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_op2_out", op2_out, 32'd0);
        checkOutput("arst_wb_out", wb_out, 32'd0);
        checkOutput("arst_wb_rd", 32'(wb_rd_addr), 32'd0);
        checkOutput("arst_wb_we", 32'(wb_we), 32'd0);
        checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
`ifdef OPSEL_FWD_EN
        fwd_v = 1'b0;
        fwd_a = '0;
        fwd_d = '0;
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Random traffic with occasional flushes and forwarding-prone addresses
        for (int n = 0; n < 120; n++) begin
            applyStimulus(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                          ($urandom_range(0, 19) == 0),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          25'($urandom), $urandom, pickAddr(), pickAddr(),
                          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
        end
        for (int n = 0; n < 3; n++) begin
            applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
